// File: rtl/fb_pixel_source.sv
// Pixel source for the TMDS transmitter: fetches RGB332 framebuffer pixels (with integer
// upscale) or draws test patterns, keeping sync/blank aligned with the RAM read latency.
module fb_pixel_source #(
   parameter int          FB_WIDTH    = 320,
   parameter int          FB_HEIGHT   = 240,
   parameter int          SCALE_SHIFT = 1,
   parameter int          ADDR_W      = 17,
   parameter int          MEM_LATENCY = 2,
   parameter int          H_TOTAL     = 800,
   parameter int          V_TOTAL     = 525,
   parameter logic [23:0] SOLID_RGB   = 24'h202080
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [10:0]       h_cnt,
   input  logic [9:0]        v_cnt,
   input  logic              h_sync_in,
   input  logic              v_sync_in,
   input  logic              blank_in,
   input  logic [1:0]        mode,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_data,
   output logic [7:0]        red_out,
   output logic [7:0]        green_out,
   output logic [7:0]        blue_out,
   output logic              h_sync_out,
   output logic              v_sync_out,
   output logic              blank_out
);

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        blank;
      logic        in_fb;
      logic [1:0]  mode;
      logic [23:0] pat;
   } ctl_t;

   localparam ctl_t       CTL_IDLE = '{hs: 1'b1, vs: 1'b0, blank: 1'b1, in_fb: 1'b0,
                                       mode: 2'd0, pat: 24'd0};
   localparam logic [1:0] SUB_MAX  = 2'((1 << SCALE_SHIFT) - 1);

   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [9:0]        row_idx_q, row_idx_d;
   logic [1:0]        sub_line_q, sub_line_d;
   logic [1:0]        mode_q, mode_eff;
   logic [10:0]       col;
   logic              in_fb;
   logic [2:0]        bar_idx;
   logic [23:0]       pat_d;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              mem_rd_q;
   ctl_t              s1_q, s1_d, dl_last;
   logic [23:0]       rgb_q, rgb_d, rgb_expanded;
   logic              hs_q, vs_q, blank_q;

   // The new mode applies from the frame-start pixel itself, not one pixel late.
   assign mode_eff = (h_cnt == 11'd0 && v_cnt == 10'd0) ? mode : mode_q;

   always_comb begin
      row_base_d = row_base_q;
      row_idx_d  = row_idx_q;
      sub_line_d = sub_line_q;
      if (h_cnt == 11'(H_TOTAL - 1)) begin
         if (v_cnt == 10'(V_TOTAL - 1)) begin
            row_base_d = '0;
            row_idx_d  = '0;
            sub_line_d = '0;
         end else if (sub_line_q == SUB_MAX) begin
            sub_line_d = '0;
            row_idx_d  = row_idx_q + 10'd1;
            row_base_d = row_base_q + ADDR_W'(FB_WIDTH);
         end else begin
            sub_line_d = sub_line_q + 2'd1;
         end
      end
   end

   assign col   = h_cnt >> SCALE_SHIFT;
   assign in_fb = ~blank_in && (col < 11'(FB_WIDTH)) && (row_idx_q < 10'(FB_HEIGHT));

   always_comb begin
      bar_idx = 3'd7;
      for (int i = 6; i >= 0; i--) begin
         if (h_cnt < 11'(80 * (i + 1))) bar_idx = 3'(i);
      end
      case (mode_eff)
         2'd1:    pat_d = {{8{bar_idx[2]}}, {8{bar_idx[1]}}, {8{bar_idx[0]}}};
         2'd2:    pat_d = {24{h_cnt[5] ^ v_cnt[5]}};
         2'd3:    pat_d = SOLID_RGB;
         default: pat_d = 24'd0;
      endcase
      s1_d = '{hs: h_sync_in, vs: v_sync_in, blank: blank_in, in_fb: in_fb,
               mode: mode_eff, pat: pat_d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_base_q <= '0;
         row_idx_q  <= '0;
         sub_line_q <= '0;
         mode_q     <= '0;
         mem_addr_q <= '0;
         mem_rd_q   <= 1'b0;
         s1_q       <= CTL_IDLE;
      end else begin
         row_base_q <= row_base_d;
         row_idx_q  <= row_idx_d;
         sub_line_q <= sub_line_d;
         mode_q     <= mode_eff;
         mem_addr_q <= row_base_q + ADDR_W'(col);
         mem_rd_q   <= in_fb && (mode_eff == 2'd0);
         s1_q       <= s1_d;
      end
   end

   // Control delay line, one stage per cycle of RAM read latency.
   for (genvar gi = 0; gi < MEM_LATENCY; gi++) begin : g_dl
      ctl_t stage_q;
      if (gi == 0) begin : g_first
         always_ff @(posedge clk) begin
            if (rst) stage_q <= CTL_IDLE;
            else     stage_q <= s1_q;
         end
      end else begin : g_rest
         always_ff @(posedge clk) begin
            if (rst) stage_q <= CTL_IDLE;
            else     stage_q <= g_dl[gi-1].stage_q;
         end
      end
   end

   assign dl_last      = g_dl[MEM_LATENCY-1].stage_q;
   assign rgb_expanded = {mem_data[7:5], mem_data[7:5], mem_data[7:6],
                          mem_data[4:2], mem_data[4:2], mem_data[4:3],
                          {4{mem_data[1:0]}}};

   always_comb begin
      if (dl_last.blank)             rgb_d = 24'd0;
      else if (dl_last.mode == 2'd0) rgb_d = dl_last.in_fb ? rgb_expanded : 24'd0;
      else                           rgb_d = dl_last.pat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_q   <= 24'd0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b0;
         blank_q <= 1'b1;
      end else begin
         rgb_q   <= rgb_d;
         hs_q    <= dl_last.hs;
         vs_q    <= dl_last.vs;
         blank_q <= dl_last.blank;
      end
   end

   assign mem_addr   = mem_addr_q;
   assign mem_rd     = mem_rd_q;
   assign red_out    = rgb_q[23:16];
   assign green_out  = rgb_q[15:8];
   assign blue_out   = rgb_q[7:0];
   assign h_sync_out = hs_q;
   assign v_sync_out = vs_q;
   assign blank_out  = blank_q;

endmodule

// File: tb/tb_fb_pixel_source.sv
// Bench for fb_pixel_source: three parameterisations share one shortened raster and are
// compared every cycle against a per-pixel reference built from the frame geometry.
module tb_fb_pixel_source;

   localparam int H_T    = 648;
   localparam int V_T    = 35;
   localparam int H_VIS  = 640;
   localparam int V_VIS  = 33;
   localparam int ADDR_W = 12;
   localparam int NDUT   = 3;
   localparam int MAXCYC = 80000;

   function automatic int fbw_of(input int i);
      if (i == 2) return 100;
      return 320;
   endfunction
   function automatic int fbh_of(input int i);
      if (i == 2) return 5;
      return 12;
   endfunction
   function automatic int sh_of(input int i);
      case (i)
         0:       return 1;
         1:       return 0;
         default: return 2;
      endcase
   endfunction
   function automatic int lat_of(input int i);
      case (i)
         0:       return 2;
         1:       return 4;
         default: return 1;
      endcase
   endfunction
   function automatic logic [23:0] solid_of(input int i);
      if (i == 2) return 24'h13579B;
      return 24'h202080;
   endfunction

   logic              clk = 1'b0;
   logic              rst;
   logic [10:0]       h_cnt;
   logic [9:0]        v_cnt;
   logic              h_sync_in, v_sync_in, blank_in;
   logic [1:0]        mode;
   logic [ADDR_W-1:0] mem_addr [NDUT];
   logic              mem_rd   [NDUT];
   logic [7:0]        mem_data [NDUT];
   logic [7:0]        red      [NDUT];
   logic [7:0]        green    [NDUT];
   logic [7:0]        blue     [NDUT];
   logic              hs_out   [NDUT];
   logic              vs_out   [NDUT];
   logic              blank_out[NDUT];
   logic [7:0]        ram [4096];

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      logic [7:0] pipe_q [4];
      always @(posedge clk) begin
         pipe_q[0] <= ram[mem_addr[gi]];
         for (int j = 1; j < 4; j++) pipe_q[j] <= pipe_q[j-1];
      end
      assign mem_data[gi] = pipe_q[lat_of(gi)-1];

      fb_pixel_source #(
         .FB_WIDTH   (fbw_of(gi)),
         .FB_HEIGHT  (fbh_of(gi)),
         .SCALE_SHIFT(sh_of(gi)),
         .ADDR_W     (ADDR_W),
         .MEM_LATENCY(lat_of(gi)),
         .H_TOTAL    (H_T),
         .V_TOTAL    (V_T),
         .SOLID_RGB  (solid_of(gi))
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .h_cnt     (h_cnt),
         .v_cnt     (v_cnt),
         .h_sync_in (h_sync_in),
         .v_sync_in (v_sync_in),
         .blank_in  (blank_in),
         .mode      (mode),
         .mem_addr  (mem_addr[gi]),
         .mem_rd    (mem_rd[gi]),
         .mem_data  (mem_data[gi]),
         .red_out   (red[gi]),
         .green_out (green[gi]),
         .blue_out  (blue[gi]),
         .h_sync_out(hs_out[gi]),
         .v_sync_out(vs_out[gi]),
         .blank_out (blank_out[gi])
      );
   end

   // Input history and the reference's view of each sampled pixel.
   bit s_rst  [MAXCYC];
   int s_h    [MAXCYC];
   int s_v    [MAXCYC];
   bit s_hs   [MAXCYC];
   bit s_vs   [MAXCYC];
   bit s_blank[MAXCYC];
   int s_mode [MAXCYC];
   int s_line [MAXCYC];

   int cyc;
   int n_checks;
   int n_errors;
   int m_mode;
   int m_origin;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cyc %0d got %h exp %h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [7:0] widen3(input int c);
      return 8'((c * 255 + 3) / 7);
   endfunction

   function automatic bit fb_hit(input int d, input int s);
      int col, row;
      col = s_h[s] >> sh_of(d);
      row = s_line[s] >> sh_of(d);
      return !s_blank[s] && col < fbw_of(d) && row < fbh_of(d);
   endfunction

   function automatic int fb_index(input int d, input int s);
      return ((s_line[s] >> sh_of(d)) * fbw_of(d) + (s_h[s] >> sh_of(d))) % 4096;
   endfunction

   function automatic logic [26:0] pixel_expect(input int d, input int s);
      logic [23:0] rgb;
      logic [7:0]  p;
      int          bar;
      rgb = 24'd0;
      if (!s_blank[s]) begin
         case (s_mode[s])
            0: if (fb_hit(d, s)) begin
                  p   = ram[fb_index(d, s)];
                  rgb = {widen3(int'(p[7:5])), widen3(int'(p[4:2])), 8'(int'(p[1:0]) * 85)};
               end
            1: begin
                  bar = s_h[s] / 80;
                  if (bar > 7) bar = 7;
                  rgb = {((bar & 4) != 0) ? 8'hFF : 8'h00,
                         ((bar & 2) != 0) ? 8'hFF : 8'h00,
                         ((bar & 1) != 0) ? 8'hFF : 8'h00};
               end
            2: rgb = (((s_h[s] / 32) + (s_v[s] / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
            default: rgb = solid_of(d);
         endcase
      end
      return {rgb, s_hs[s], s_vs[s], s_blank[s]};
   endfunction

   task automatic check_cycle(input int c);
      int          lat;
      bit          idle;
      logic [26:0] exp_pix;
      logic [26:0] got_pix;
      bit          exp_rd;
      logic [ADDR_W-1:0] exp_addr;
      logic [ADDR_W-1:0] got_addr;
      for (int d = 0; d < NDUT; d++) begin
         lat  = lat_of(d) + 2;
         idle = (c - lat < 0);
         for (int k = c - lat; k < c; k++) if (k >= 0 && s_rst[k]) idle = 1'b1;
         exp_pix = idle ? {24'd0, 1'b1, 1'b0, 1'b1} : pixel_expect(d, c - lat);
         got_pix = {red[d], green[d], blue[d], hs_out[d], vs_out[d], blank_out[d]};
         check_value($sformatf("pix%0d", d), 64'(got_pix), 64'(exp_pix));

         idle     = (c - 1 < 0) || s_rst[c-1];
         exp_rd   = !idle && s_mode[c-1] == 0 && fb_hit(d, c - 1);
         exp_addr = exp_rd ? ADDR_W'(fb_index(d, c - 1)) : '0;
         got_addr = (exp_rd || idle) ? mem_addr[d] : '0;
         check_value($sformatf("mem%0d", d), 64'({mem_rd[d], got_addr}), 64'({exp_rd, exp_addr}));
      end
   endtask

   task automatic drive(input bit r, input int h, input int v, input logic [1:0] md);
      rst       = r;
      h_cnt     = 11'(h);
      v_cnt     = 10'(v);
      h_sync_in = !(h >= 642 && h < 646);
      v_sync_in = (v == 33);
      blank_in  = (h >= H_VIS) || (v >= V_VIS);
      mode      = md;
      if (r) begin
         m_mode   = 0;
         m_origin = v;
      end else if (h == 0 && v == 0) begin
         m_mode = int'(md);
      end
      s_rst[cyc]   = r;
      s_h[cyc]     = h;
      s_v[cyc]     = v;
      s_hs[cyc]    = h_sync_in;
      s_vs[cyc]    = v_sync_in;
      s_blank[cyc] = blank_in;
      s_mode[cyc]  = m_mode;
      s_line[cyc]  = v - m_origin;
      if (!r && h == H_T - 1 && v == V_T - 1) m_origin = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      check_cycle(cyc);
   endtask

   initial begin
      logic [1:0] frame_mode [4];
      logic [1:0] md;
      bit         r;
      frame_mode = '{2'd0, 2'd1, 2'd2, 2'd3};
      n_checks = 0;
      n_errors = 0;
      cyc      = 0;
      m_mode   = 0;
      m_origin = 0;
      for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);

      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 0, 0, 2'd0);
         step();
      end

      // Frame 2 takes a short reset mid-frame; frame 3 is cut short after a few lines.
      for (int f = 0; f < 4; f++) begin
         for (int v = 0; v < ((f == 3) ? 4 : V_T); v++) begin
            for (int h = 0; h < H_T; h++) begin
               r  = (f == 2 && v == 20 && h >= 300 && h < 303);
               md = (h == 0 && v == 0) ? frame_mode[f] : 2'($urandom_range(3, 0));
               drive(r, h, v, md);
               step();
            end
         end
         $display("frame %0d mode %0d checks %0d errors %0d", f, frame_mode[f], n_checks, n_errors);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fb_pixel_source.md
Name: fb_pixel_source

Overview:
- Upstream pixel generator that feeds the TMDS transmitter.
- Consumes the pixel counters, sync and blank from the 640x480 timing generator.
- Fetches pixels from an external RGB332 framebuffer RAM, with optional integer upscale, or generates test patterns.
- Emits 8-bit R/G/B with sync and blank delayed to match, so they align exactly at the transmitter inputs.

Parameters:
- FB_WIDTH, 320, framebuffer width in pixels.
- FB_HEIGHT, 240, framebuffer height in lines.
- SCALE_SHIFT, 1, upscale factor 2^SCALE_SHIFT in both axes (allowed 0..2).
- ADDR_W, 17, framebuffer address width (must hold FB_WIDTH*FB_HEIGHT-1).
- MEM_LATENCY, 2, RAM read latency in cycles, from mem_addr sampled to mem_data valid (allowed 1..4).
- H_TOTAL, 800, pixels per line including blanking.
- V_TOTAL, 525, lines per frame including blanking.
- SOLID_RGB, 24'h202080, mode-3 colour {R,G,B}.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset; synchronous to clk, active-high.
- h_cnt  in  11  current X from the timing generator (0..H_TOTAL-1).
- v_cnt  in  10  current Y from the timing generator (0..V_TOTAL-1).
- h_sync_in  in  1  horizontal sync, active-low.
- v_sync_in  in  1  vertical sync.
- blank_in  in  1  1 = non-visible pixel.
- mode  in  2  0 framebuffer, 1 colour bars, 2 checkerboard, 3 solid.
- mem_addr  out  ADDR_W  framebuffer read address.
- mem_rd  out  1  read strobe.
- mem_data  in  8  RGB332 pixel, valid MEM_LATENCY cycles after its address.
- red_out  out  8  red component.
- green_out  out  8  green component.
- blue_out  out  8  blue component.
- h_sync_out  out  1  delayed h_sync_in.
- v_sync_out  out  1  delayed v_sync_in.
- blank_out  out  1  delayed blank_in.

Behaviour:
- Total latency L = MEM_LATENCY+2 cycles, from an input sample to the corresponding output, for all outputs.
- Pipeline stages:
  - Stage 1 registers mem_addr, mem_rd and the pattern colour.
  - Stage 2..L-1 form a delay line for sync, blank, pattern colour and mode; length matches MEM_LATENCY.
  - Stage L is the output register.
- Reset state:
  - All outputs: RGB 0, mem_addr 0, mem_rd 0, h_sync_out 1, v_sync_out 0, blank_out 1.
  - Every delay-line stage loads these same idle values.
  - row_base, row_idx, sub_line and mode_q are 0.
  - Reset asserted mid-frame takes effect on the next edge. Outputs are idle for L cycles after deassertion until fresh data propagates.
- Mode latch: mode_q <= mode only when h_cnt==0 && v_cnt==0. A mode change mid-frame is ignored until the next frame start.
- Line tracking: on the cycle h_cnt==H_TOTAL-1:
  - If v_cnt==V_TOTAL-1: row_base, row_idx and sub_line are set to 0.
  - Else, if sub_line==2^SCALE_SHIFT-1: sub_line<=0, row_idx<=row_idx+1, row_base<=row_base+FB_WIDTH.
  - Otherwise sub_line<=sub_line+1.
  - No multiplier is used.
- Address generation:
  - col = h_cnt>>SCALE_SHIFT.
  - in_fb = ~blank_in && col<FB_WIDTH && row_idx<FB_HEIGHT.
  - mem_addr <= row_base+col, truncated to ADDR_W.
  - mem_rd <= in_fb && mode_q==0.
  - When mem_rd is 0, mem_addr still updates; its value is don't-care.
- RGB332 expansion:
  - R = {p[7:5],p[7:5],p[7:6]}.
  - G = {p[4:2],p[4:2],p[4:3]}.
  - B = {p[1:0],p[1:0],p[1:0],p[1:0]}.
- Patterns, computed at stage 1 from h_cnt/v_cnt:
  - Mode 1: eight 80-pixel bars, index 0..7 chosen by comparator chain (h_cnt<80, <160, ...). Colour per bar: R=index[2]?FF:00, G=index[1]?FF:00, B=index[0]?FF:00. Bar 0 is black, bar 7 is white.
  - Mode 2: white when h_cnt[5]^v_cnt[5] is 1, else black (32-pixel squares).
  - Mode 3: SOLID_RGB.
- Output select at stage L:
  - If the delayed blank is 1: RGB = 0.
  - Else if mode 0: out-of-framebuffer pixels (delayed in_fb==0) are black; otherwise the expanded mem_data.
  - Else: the delayed pattern colour.

Test Plan:
- Reset then free-run timing, mode 0, RAM holding addr[7:0] as data, SCALE_SHIFT=1 → first visible output pixel appears L=4 cycles after (0,0) is input. mem_addr sequence is 0,0,1,1,2,... Output (0,0)=RGB 000000, pixel with data 8'hE0 → R=FF.
- Line repeat: SCALE_SHIFT=1 → lines 0 and 1 both fetch base 0, line 2 fetches base 320, line 479 fetches base 239*320=76480. The next frame restarts at 0.
- Mode 1 → output pixel x=79 is 000000, x=80 is 0000FF, x=639 is FFFFFF. During blank all outputs are 0 and blank_out=1.
- Mode changed 0→2 at v_cnt=100 → no change until the next (0,0). Then pixel (32,0)=FFFFFF and (32,32)=000000. mem_rd stays 0 for the whole frame.
- Sync alignment: h_sync_out and v_sync_out equal h_sync_in/v_sync_in delayed exactly L cycles across a full frame, for MEM_LATENCY=1 and MEM_LATENCY=4.
- Reset asserted at h_cnt=300, v_cnt=200 → next cycle all outputs idle (h_sync_out 1, blank_out 1, RGB 0). After deassertion, row tracking restarts at row_base 0 and the first correctly addressed pixel appears in the next frame.
